serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port x  input  WIDTH  first operand; captured when start is accepted.
REQ-006 SHALL have port y  input  WIDTH  second operand; captured when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in; captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress (state ADD).
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a new result on sum/cout.
REQ-010 SHALL have port sum  output  WIDTH  registered result, x + y + cin modulo 2^WIDTH.
REQ-011 SHALL have port cout  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, ADD, DONE.
REQ-013 IDLE: start=1 at an edge SHALL load x and y into internal shift registers, load cin into the carry flop, clear the bit counter and move to ADD; start=0 keeps IDLE.
REQ-014 ADD: each edge SHALL take bit 0 of both shift registers plus the carry flop through one full-adder cell (sum = a xor b xor c; carry = ab | c(a xor b)).
REQ-015 ADD: each edge SHALL shift both operand registers right by one, shift the sum bit into the MSB of an internal result register, store the new carry and increment the counter.
REQ-016 Bit i (LSB first, i = 0..WIDTH-1) SHALL be processed at edge k+1+i, where k is the edge that accepted start.
REQ-017 At edge k+WIDTH the FSM SHALL move to DONE and the completed result and final carry SHALL be copied to sum and cout in the same edge.
REQ-018 done SHALL be high for exactly one cycle, after edge k+WIDTH; the FSM SHALL return to IDLE at edge k+WIDTH+1.
REQ-019 Latency: start accepted at edge k gives a valid result with done=1 after edge k+WIDTH; throughput is one addition per WIDTH+2 cycles.
REQ-020 sum and cout SHALL hold their last value until the next completion; they SHALL NOT show partial results while busy.
REQ-021 start SHALL be ignored in ADD and DONE, with no queuing; a start held high through DONE SHALL be accepted in IDLE at edge k+WIDTH+2.
REQ-022 Changes on x, y or cin after the accepting edge SHALL have no effect on the addition in progress.
REQ-023 The counter SHALL be wide enough for WIDTH, with no wrap before the terminal count; WIDTH=1 SHALL complete in one ADD cycle.
REQ-024 busy SHALL be 1 exactly in ADD, and done SHALL be 1 exactly in DONE.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE and clear to 0: busy, done, sum, cout, the carry flop, the counter and all shift registers.
REQ-026 Reset asserted during ADD or DONE SHALL abort the addition; no done pulse SHALL follow, and the next start after release SHALL begin a fresh addition.
REQ-027 The first edge after rst_n rises SHALL behave as an IDLE edge.

Verification
REQ-028 WIDTH=8, x=0x5A, y=0x3C, cin=0, start for 1 cycle -> busy for 8 cycles, done pulses once 8 edges after acceptance, sum=0x96, cout=0.
REQ-029 WIDTH=8: 0xFF+0x01 cin=0 -> sum=0x00, cout=1; then 0xFF+0xFF cin=1 -> sum=0xFF, cout=1; then 0x00+0x00 cin=0 -> sum=0x00, cout=0.
REQ-030 WIDTH=1: all 8 combinations of x, y, cin -> sum/cout match the full-adder truth table (for example 1,1,1 -> sum=1, cout=1), with done one edge after acceptance.
REQ-031 Pulse start again at edge k+3 with different operands, and change x/y mid-operation -> result equals the first operands only, with a single done pulse.
REQ-032 Assert rst_n=0 at edge k+4 of a WIDTH=8 addition -> all outputs read 0 immediately with no done pulse; after release, 0x12+0x34 cin=0 -> sum=0x46, cout=0.
REQ-033 Random regression, 1000 WIDTH=8 additions with random start spacing -> every done reports {cout,sum} = x+y+cin against a reference model.

Source files
------------

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial WIDTH-bit adder, LSB first, one full-adder cell per clock.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_sbit;
    logic             w_cbit;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    assign w_sbit = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cbit = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_last = (r_cnt == c_last_bit);
    assign busy   = (r_state == ADD);
    assign done   = (r_state == DONE);

    // Partial result holds the WIDTH-1 bits already produced; the newest bit
    // enters at the MSB so the completed word is available combinationally.
    generate
        if (WIDTH > 1) begin : g_wide
            logic [WIDTH-2:0] r_res;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_res <= '0;
                else if (r_state == ADD)
                    r_res <= w_res_next[WIDTH-1:1];
            end
            assign w_res_next = {w_sbit, r_res};
        end else begin : g_narrow
            assign w_res_next = w_sbit;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = ADD;
            ADD:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= x;
                        r_b     <= y;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                ADD: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_cbit;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        sum  <= w_res_next;
                        cout <= w_cbit;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Directed and random self-checking bench for serial_adder (WIDTH 8 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] x8, y8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] x1, y1, sum1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .x(x8), .y(y8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .x(x1), .y(y1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    // Launch one 8-bit addition, scramble operands after acceptance, and
    // report edges from acceptance to done plus the number of busy samples.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat, output int busy_n);
        @(negedge clk);
        start8 = 1'b1; x8 = a; y8 = b; cin8 = c;
        @(negedge clk);
        start8 = 1'b0; x8 = ~a; y8 = ~b; cin8 = ~c;
        lat = 0; busy_n = 0;
        while (!done8 && lat < 30) begin
            if (busy8) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b0; x8 = '0; y8 = '0; cin8 = 1'b0;
        start1 = 1'b0; x1 = '0; y1 = '0; cin1 = 1'b0;
        #3;
        n_checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
        end
        n_checks++;
        if ({busy1, done1, sum1, cout1} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset1: got busy=%b done=%b sum=%h cout=%b, want all 0", busy1, done1, sum1, cout1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bn;
        run8(8'h5A, 8'h3C, 1'b0, lat, bn);
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d, want 8", lat);
        end
        n_checks++;
        if (bn !== 8) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", bn);
        end
        n_checks++;
        if ({cout8, sum8} !== 9'h096) begin
            n_fail++;
            $display("FAIL basic_sum: got cout=%b sum=%h, want cout=0 sum=96", cout8, sum8);
        end
        @(negedge clk);
        n_checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got done=%b busy=%b after pulse, want 0 0", done8, busy8);
        end
    endtask

    task automatic test_carry();
        logic [7:0] va [3] = '{8'hFF, 8'hFF, 8'h00};
        logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h00};
        logic       vc [3] = '{1'b0, 1'b1, 1'b0};
        logic [8:0] ve [3] = '{9'h100, 9'h1FF, 9'h000};
        int lat, bn;
        for (int i = 0; i < 3; i++) begin
            run8(va[i], vb[i], vc[i], lat, bn);
            n_checks++;
            if (lat !== 8 || {cout8, sum8} !== ve[i]) begin
                n_fail++;
                $display("FAIL carry_%0d: got lat=%0d {cout,sum}=%h, want lat=8 %h", i, lat, {cout8, sum8}, ve[i]);
            end
        end
    endtask

    task automatic test_width1();
        // {cout,sum} for index {x,y,cin}
        logic [1:0] exp_tbl [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        logic [2:0] v;
        int lat;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            start1 = 1'b1; x1 = v[2]; y1 = v[1]; cin1 = v[0];
            @(negedge clk);
            start1 = 1'b0; x1 = ~v[2]; y1 = ~v[1]; cin1 = ~v[0];
            lat = 0;
            while (!done1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            n_checks++;
            if (lat !== 1 || {cout1, sum1} !== exp_tbl[i]) begin
                n_fail++;
                $display("FAIL width1_%0d: got lat=%0d {cout,sum}=%b, want lat=1 %b", i, lat, {cout1, sum1}, exp_tbl[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int         n_done = 0;
        logic [8:0] first  = 9'h1AA;
        @(negedge clk);
        start8 = 1'b1; x8 = 8'h5A; y8 = 8'h3C; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0; x8 = 8'h11; y8 = 8'h22;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; x8 = 8'hF0; y8 = 8'h0F; cin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; x8 = 8'h33;
        for (int n = 0; n < 14; n++) begin
            if (done8) begin
                n_done++;
                if (n_done == 1) first = {cout8, sum8};
            end
            @(negedge clk);
        end
        n_checks++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL ignore_done_count: got %0d, want 1", n_done);
        end
        n_checks++;
        if (first !== 9'h096) begin
            n_fail++;
            $display("FAIL ignore_sum: got %h, want 096", first);
        end
    endtask

    task automatic test_back_to_back();
        int d1 = -1, d2 = -1;
        @(negedge clk);
        start8 = 1'b1; x8 = 8'h80; y8 = 8'h80; cin8 = 1'b1;
        for (int n = 1; n <= 40 && d2 < 0; n++) begin
            @(negedge clk);
            if (done8) begin
                if (d1 < 0) d1 = n;
                else d2 = n;
            end
        end
        start8 = 1'b0;
        n_checks++;
        if (d1 !== 9 || d2 !== 19) begin
            n_fail++;
            $display("FAIL b2b_timing: got done at %0d,%0d, want 9,19", d1, d2);
        end
        n_checks++;
        if ({cout8, sum8} !== 9'h101) begin
            n_fail++;
            $display("FAIL b2b_sum: got %h, want 101", {cout8, sum8});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int n_done = 0;
        int lat    = 0;
        @(negedge clk);
        start8 = 1'b1; x8 = 8'hA5; y8 = 8'h5A; cin8 = 1'b1;
        repeat (4) @(negedge clk);
        start8 = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            n_fail++;
            $display("FAIL abort_async_clear: got busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
        end
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done8) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d pulses, want 0", n_done);
        end
        // Release together with start: the first edge after reset must accept.
        rst_n = 1'b1;
        start8 = 1'b1; x8 = 8'h12; y8 = 8'h34; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0; x8 = 8'hFF; y8 = 8'hFF;
        while (!done8 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 8 || {cout8, sum8} !== 9'h046) begin
            n_fail++;
            $display("FAIL abort_restart: got lat=%0d {cout,sum}=%h, want lat=8 046", lat, {cout8, sum8});
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        logic       c;
        logic [8:0] expv;
        int lat, bn;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
            expv = {1'b0, a} + {1'b0, b} + {8'd0, c};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run8(a, b, c, lat, bn);
            n_checks++;
            if (lat !== 8 || {cout8, sum8} !== expv) begin
                n_fail++;
                $display("FAIL random_%0d: %h+%h+%b got lat=%0d %h, want lat=8 %h", i, a, b, c, lat, {cout8, sum8}, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_width1();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
